// File: rtl/ctrl_in_demux_seq.sv
// ctrl_in_demux_seq: load-phase sequencer that spreads one input stream
// round-robin across up to 4 SMAC block input buffers.
// Optional feature macro: CTRL_IN_DEMUX_BCAST_EN (adds the bcast input; when
// bcast is set at start, every accepted word goes to all active blocks).
module ctrl_in_demux_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_clear,
  input  logic              cnt_load,
  input  logic [2:0]        max_val,
  input  logic [ADDR_W:0]   words_per_blk,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef CTRL_IN_DEMUX_BCAST_EN
  input  logic              bcast,
`endif
  output logic              in_ready,
  output logic [3:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        sel_demux,
  output logic              rnd_done,
  output logic              load_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        cfg_max_r, cfg_max_s;
  logic [ADDR_W:0]   cfg_words_r, cfg_words_s;
  logic [1:0]        blk_idx_r, blk_idx_s;
  logic [ADDR_W:0]   addr_r, addr_s;
  logic              bcast_r, bcast_s;
  logic [3:0]        wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_s;
  logic              rnd_done_r, rnd_done_s;
  logic              last_blk_s, last_addr_s;

  // Write-enable mask covering the low n active blocks (n already clamped to 0..4).
  function automatic logic [3:0] blk_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign last_blk_s  = ({1'b0, blk_idx_r} == (cfg_max_r - 3'd1));
  assign last_addr_s = (addr_r == (cfg_words_r - (ADDR_W+1)'(1)));

  // Next-state, counters and write-port values for the coming cycle.
  always_comb begin
    state_s     = state_r;
    cfg_max_s   = cfg_max_r;
    cfg_words_s = cfg_words_r;
    blk_idx_s   = blk_idx_r;
    addr_s      = addr_r;
    bcast_s     = bcast_r;
    wr_en_s     = 4'b0000;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    rnd_done_s  = 1'b0;
    if (cnt_clear) begin
      // Abort: counters and outputs clear, configuration is kept.
      state_s   = ST_IDLE;
      blk_idx_s = 2'd0;
      addr_s    = '0;
      bcast_s   = 1'b0;
      wr_addr_s = '0;
      wr_data_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cnt_load) begin
            cfg_max_s   = (max_val > 3'd4) ? 3'd4 : max_val;
            cfg_words_s = words_per_blk;
          end else if (start && (cfg_max_r != 3'd0) && (cfg_words_r != '0)) begin
            state_s   = ST_LOAD;
            blk_idx_s = 2'd0;
            addr_s    = '0;
`ifdef CTRL_IN_DEMUX_BCAST_EN
            bcast_s   = bcast;
`else
            bcast_s   = 1'b0;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            wr_addr_s = addr_r[ADDR_W-1:0];
            wr_data_s = in_data;
            if (bcast_r) begin
              // Broadcast: one word fills the same address in every active block.
              wr_en_s    = blk_mask(cfg_max_r);
              rnd_done_s = 1'b1;
              addr_s     = addr_r + (ADDR_W+1)'(1);
              if (last_addr_s) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_LOAD;
              end
            end else begin
              wr_en_s = 4'b0001 << blk_idx_r;
              if (last_blk_s) begin
                blk_idx_s  = 2'd0;
                addr_s     = addr_r + (ADDR_W+1)'(1);
                rnd_done_s = 1'b1;
                if (last_addr_s) begin
                  state_s = ST_DONE;
                end else begin
                  state_s = ST_LOAD;
                end
              end else begin
                blk_idx_s = blk_idx_r + 2'd1;
              end
            end
          end else begin
            // Stall: nothing written, counters hold.
            wr_en_s = 4'b0000;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, configuration, counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_max_r   <= 3'd0;
      cfg_words_r <= '0;
      blk_idx_r   <= 2'd0;
      addr_r      <= '0;
      bcast_r     <= 1'b0;
      wr_en_r     <= 4'b0000;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      rnd_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cfg_max_r   <= cfg_max_s;
      cfg_words_r <= cfg_words_s;
      blk_idx_r   <= blk_idx_s;
      addr_r      <= addr_s;
      bcast_r     <= bcast_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      rnd_done_r  <= rnd_done_s;
    end
  end

  // in_ready, load_done and busy decode straight from the state register.
  assign in_ready  = (state_r == ST_LOAD);
  assign load_done = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign sel_demux = blk_idx_r;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign rnd_done  = rnd_done_r;

endmodule

// File: tb/tb_ctrl_in_demux_seq.sv
// Self-checking bench for ctrl_in_demux_seq: directed steps plus randomized
// loads, checked against a queue of expected writes built from the config.
module tb_ctrl_in_demux_seq;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cnt_clear = 1'b0;
  logic              cnt_load = 1'b0;
  logic [2:0]        max_val = 3'd0;
  logic [ADDR_W:0]   words_per_blk = '0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
`ifdef CTRL_IN_DEMUX_BCAST_EN
  logic              bcast = 1'b0;
`endif
  logic              in_ready;
  logic [3:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        sel_demux;
  logic              rnd_done;
  logic              load_done;
  logic              busy;

  ctrl_in_demux_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_clear(cnt_clear), .cnt_load(cnt_load),
    .max_val(max_val), .words_per_blk(words_per_blk), .start(start),
    .in_valid(in_valid), .in_data(in_data),
`ifdef CTRL_IN_DEMUX_BCAST_EN
    .bcast(bcast),
`endif
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel_demux(sel_demux), .rnd_done(rnd_done), .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    int         addr;
    logic       rnd;
    logic [1:0] sel;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_max   = 0;
  int  m_words = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int mv, input int w);
    max_val       = 3'(mv);
    words_per_blk = (ADDR_W+1)'(w);
    cnt_load      = 1'b1;
    cycle();
    cnt_load = 1'b0;
    m_max    = (mv > 4) ? 4 : mv;
    m_words  = w;
    chk("busy_after_cfg", busy, 0);
  endtask

  // Start a load; the expected write list is every (address, block) pair in order.
  task automatic do_start(input logic b);
    wr_t e;
`ifdef CTRL_IN_DEMUX_BCAST_EN
    bcast = b;
`endif
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_after_start", busy, (m_max != 0 && m_words != 0));
    exp_q.delete();
    if (m_max != 0 && m_words != 0) begin
      chk("sel_at_start", sel_demux, 0);
      for (int a = 0; a < m_words; a++) begin
        if (b) begin
          e.en = 4'((1 << m_max) - 1); e.addr = a; e.rnd = 1'b1; e.sel = 2'd0;
          exp_q.push_back(e);
        end else begin
          for (int k = 0; k < m_max; k++) begin
            e.en = 4'(1 << k); e.addr = a; e.rnd = (k == m_max - 1); e.sel = 2'(k);
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic word(input logic v, input logic [DATA_W-1:0] d);
    wr_t  e;
    logic acc;
    in_valid = v;
    in_data  = d;
    acc = v && (exp_q.size() != 0);
    chk("in_ready", in_ready, (exp_q.size() != 0));
    if (acc) chk("sel_demux", sel_demux, exp_q[0].sel);
    cycle();
    in_valid = 1'b0;
    if (acc) begin
      e = exp_q.pop_front();
      chk("wr_en", wr_en, e.en);
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_data", wr_data, d);
      chk("rnd_done", rnd_done, e.rnd);
      chk("load_done", load_done, (exp_q.size() == 0));
      chk("busy_load", busy, 1);
      if (exp_q.size() == 0) chk("in_ready_done", in_ready, 0);
    end else begin
      chk("wr_en_idle", wr_en, 0);
      chk("load_done_idle", load_done, 0);
    end
  endtask

  // mode 0: back-to-back, 1: valid on every third cycle, 2: random valid.
  task automatic run_load(input int mode);
    int  i;
    logic v;
    i = 0;
    while (exp_q.size() != 0) begin
      if (i > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: observed %0d writes pending expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = ((i % 3) == 0);
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      word(v, 8'($urandom));
      i++;
    end
    word(1'b1, 8'h5a);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_sel", sel_demux, 0);
    chk("rst_rnd", rnd_done, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycle();
    // Start with unconfigured (zero) config is ignored
    do_start(1'b0);

    // Full load: 4 blocks x 3 words, back-to-back
    do_cfg(4, 3);
    do_start(1'b0);
    run_load(0);

    // Partial array and clamp of max_val
    do_cfg(2, 2);
    do_start(1'b0);
    run_load(0);
    do_cfg(7, 2);
    do_start(1'b0);
    run_load(0);

    // Stalls
    do_cfg(3, 2);
    do_start(1'b0);
    run_load(1);

    // Abort after 5 of 8 words (data also offered on the clear cycle)
    do_cfg(4, 2);
    do_start(1'b0);
    for (int i = 0; i < 5; i++) word(1'b1, 8'(i));
    cnt_clear = 1'b1;
    in_valid  = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    in_valid  = 1'b0;
    exp_q.delete();
    chk("clr_wr_en", wr_en, 0);
    chk("clr_busy", busy, 0);
    chk("clr_load_done", load_done, 0);
    chk("clr_sel", sel_demux, 0);
    chk("clr_wr_addr", wr_addr, 0);
    chk("clr_rnd", rnd_done, 0);
    cycle();
    chk("clr_load_done_later", load_done, 0);
    // Config retained; cnt_load while loading is ignored
    do_start(1'b0);
    max_val       = 3'd1;
    words_per_blk = (ADDR_W+1)'(1);
    cnt_load      = 1'b1;
    cycle();
    cnt_load = 1'b0;
    chk("busy_cnt_load", busy, 1);
    run_load(0);
    // Zero words config -> start ignored
    do_cfg(2, 0);
    do_start(1'b0);

    // Reset mid-load clears everything including the config
    do_cfg(4, 3);
    do_start(1'b0);
    for (int i = 0; i < 5; i++) word(1'b1, 8'(8'h10 + i));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_sel", sel_demux, 0);
    exp_q.delete();
    m_max   = 0;
    m_words = 0;
    cycle();
    rst_n = 1'b1;
    cycle();
    do_start(1'b0);

    // Randomized loads
    for (int r = 0; r < 12; r++) begin
      do_cfg($urandom_range(1, 7), $urandom_range(1, 6));
      do_start(1'b0);
      run_load(2);
    end
    // Largest address range once
    do_cfg(1, 64);
    do_start(1'b0);
    run_load(0);

`ifdef CTRL_IN_DEMUX_BCAST_EN
    // Broadcast load, then round-robin again
    do_cfg(3, 4);
    do_start(1'b1);
    run_load(0);
    do_start(1'b0);
    run_load(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
